// File: rtl/uart_pkg.sv
// uart_pkg: uart register map, arbiter state encoding and grant constants
package uart_pkg;
    localparam logic [1:0] UART_ADDR_TX  = 2'd0;
    localparam logic [1:0] UART_ADDR_RX  = 2'd1;
    localparam logic [1:0] UART_ADDR_DIV = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: two-requester round-robin selector, one-hot pick, favours the master that did not own last
module uart_rr_pick
    import uart_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);
    // a lone requester wins outright; a tie goes to the one that is not last owner
    always_comb pick = (req == 2'b11) ? (last ? GNT_M0 : GNT_M1) : req;
endmodule

// File: rtl/uart_wb_arbiter.sv
// uart_wb_arbiter: round-robin share of the uart register port between two masters (optional watchdog: UART_ARB_TIMEOUT_EN)
module uart_wb_arbiter
    import uart_pkg::*;
#(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_in,
    output logic [DATA_W-1:0] m0_data_out,
    input  logic              m0_we,
    input  logic              m0_clk,
    input  logic              m0_stb,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_in,
    output logic [DATA_W-1:0] m1_data_out,
    input  logic              m1_we,
    input  logic              m1_clk,
    input  logic              m1_stb,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data_in,
    input  logic [DATA_W-1:0] s_data_out,
    output logic              s_we,
    output logic              s_clk,
    output logic              s_stb,
    input  logic              s_ack,
    output logic [1:0]        grant,
    output logic              busy
);
    arb_state_t state_q, state_d;
    logic [1:0] grant_q, pick;
    logic       last_q, ack_seen_q, timeout, fwd;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("uart_wb_arbiter: TIMEOUT_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    uart_rr_pick u_pick (
        .req  ({m1_stb, m0_stb}),
        .last (last_q),
        .pick (pick)
    );

`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wdog_q;

    // count unacknowledged GRANT cycles; held at zero outside GRANT so each grant starts fresh
    always_ff @(posedge clk or posedge reset)
        if (reset)
            wdog_q <= '0;
        else if (state_q != ST_GRANT)
            wdog_q <= '0;
        else if (!ack_seen_q)
            wdog_q <= wdog_q + 1'b1;

    assign timeout = (state_q == ST_GRANT) && !ack_seen_q && !s_ack &&
                     (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // state, owner, round-robin pointer and ack handshake tracking
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= GNT_NONE;
            last_q     <= 1'b1;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= (state_q == ST_IDLE) ? pick : ((state_d == ST_GRANT) ? grant_q : GNT_NONE);
            ack_seen_q <= (state_q == ST_GRANT) && (state_d == ST_GRANT) && (ack_seen_q || s_ack);
            if (state_q == ST_IDLE && pick != GNT_NONE)
                last_q <= pick[1];
        end

    // leave GRANT once the ack has risen and fallen (or the watchdog fires); RELEASE lasts one cycle
    always_comb
        state_d = (state_q == ST_IDLE)  ? ((pick != GNT_NONE) ? ST_GRANT : ST_IDLE) :
                  (state_q == ST_GRANT) ? (((ack_seen_q && !s_ack) || timeout) ? ST_RELEASE : ST_GRANT) :
                  ST_IDLE;

    // forward the owner's bus to the uart and route ack/data back; everything idles low when no owner
    always_comb begin
        fwd         = (grant_q != GNT_NONE);
        s_addr      = fwd ? (grant_q[1] ? m1_addr    : m0_addr)    : '0;
        s_data_in   = fwd ? (grant_q[1] ? m1_data_in : m0_data_in) : '0;
        s_we        = fwd && (grant_q[1] ? m1_we  : m0_we);
        s_clk       = fwd && (grant_q[1] ? m1_clk : m0_clk);
        s_stb       = fwd && (grant_q[1] ? m1_stb : m0_stb);
        m0_ack      = grant_q[0] && s_ack;
        m1_ack      = grant_q[1] && s_ack;
        m0_data_out = grant_q[0] ? s_data_out : '0;
        m1_data_out = grant_q[1] ? s_data_out : '0;
        m0_err      = grant_q[0] && timeout;
        m1_err      = grant_q[1] && timeout;
        grant       = grant_q;
        busy        = (state_q != ST_IDLE);
    end
endmodule

// File: tb/tb_uart_wb_arbiter.sv
// tb_uart_wb_arbiter: directed table-driven bench for uart_wb_arbiter (build with UART_ARB_TIMEOUT_EN to cover the watchdog)
module tb_uart_wb_arbiter;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] m0_addr = '0, m1_addr = '0, s_addr;
    logic [7:0] m0_data_in = '0, m1_data_in = '0, m0_data_out, m1_data_out;
    logic [7:0] s_data_in, s_data_out = '0;
    logic       m0_we = 1'b0, m0_clk = 1'b0, m0_stb = 1'b0, m0_ack, m0_err;
    logic       m1_we = 1'b0, m1_clk = 1'b0, m1_stb = 1'b0, m1_ack, m1_err;
    logic       s_we, s_clk, s_stb, s_ack = 1'b0, busy;
    logic [1:0] grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_wb_arbiter #(.ADDR_W(2), .DATA_W(8), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_data_in(m0_data_in), .m0_data_out(m0_data_out), .m0_we(m0_we),
        .m0_clk(m0_clk), .m0_stb(m0_stb), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_data_in(m1_data_in), .m1_data_out(m1_data_out), .m1_we(m1_we),
        .m1_clk(m1_clk), .m1_stb(m1_stb), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_addr(s_addr), .s_data_in(s_data_in), .s_data_out(s_data_out),
        .s_we(s_we), .s_clk(s_clk), .s_stb(s_stb), .s_ack(s_ack),
        .grant(grant), .busy(busy)
    );

    // master config packed as {stb, we, addr[1:0], data[7:0]}
    localparam logic [11:0] MI  = 12'h000;
    localparam logic [11:0] W11 = {1'b1, 1'b0, UART_ADDR_TX,  8'h11};
    localparam logic [11:0] W22 = {1'b1, 1'b0, UART_ADDR_DIV, 8'h22};
    localparam logic [11:0] R1  = {1'b1, 1'b1, UART_ADDR_RX,  8'h00};
    localparam logic [11:0] W41 = {1'b1, 1'b0, UART_ADDR_TX,  8'h41};
    localparam logic [11:0] D41 = {1'b0, 1'b0, UART_ADDR_TX,  8'h41};

    typedef struct {
        logic [11:0] c0, c1;
        logic        ack;
        logic [7:0]  dout;
        logic [1:0]  e_grant;
        logic        e_stb, e_we;
        logic [1:0]  e_addr;
        logic [7:0]  e_din;
        logic        e_a0, e_a1;
        logic [7:0]  e_d0, e_d1;
        logic        e_busy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [11:0] c0, logic [11:0] c1, logic ack, logic [7:0] dout,
                                logic [1:0] g, logic stb, logic we, logic [1:0] addr, logic [7:0] din,
                                logic a0, logic a1, logic [7:0] d0, logic [7:0] d1, logic bz);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.ack = ack; v.dout = dout;
        v.e_grant = g; v.e_stb = stb; v.e_we = we; v.e_addr = addr; v.e_din = din;
        v.e_a0 = a0; v.e_a1 = a1; v.e_d0 = d0; v.e_d1 = d1; v.e_busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] c0, input logic [11:0] c1, input logic ack, input logic [7:0] dout);
        {m0_stb, m0_we, m0_addr, m0_data_in} = c0;
        {m1_stb, m1_we, m1_addr, m1_data_in} = c1;
        m0_clk = c0[11];
        m1_clk = c1[11];
        s_ack = ack;
        s_data_out = dout;
    endtask

    initial begin
        int errs;
        int err_at;
        logic [1:0] g16, g17;
        logic stb17;

        // contention from reset: 0,1,0,1
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b01, 1, 0, 2'd0, 8'h11, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 1, 8'h00, 2'b01, 1, 0, 2'd0, 8'h11, 1, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b01, 1, 0, 2'd0, 8'h11, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b10, 1, 0, 2'd2, 8'h22, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 1, 8'h00, 2'b10, 1, 0, 2'd2, 8'h22, 0, 1, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b10, 1, 0, 2'd2, 8'h22, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tv.push_back(mk(W11, W22, 1, 8'h77, 2'b01, 1, 0, 2'd0, 8'h11, 1, 0, 8'h77, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h77, 2'b01, 1, 0, 2'd0, 8'h11, 0, 0, 8'h77, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h77, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tv.push_back(mk(W11, W22, 1, 8'h88, 2'b10, 1, 0, 2'd2, 8'h22, 0, 1, 8'h00, 8'h88, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b10, 1, 0, 2'd2, 8'h22, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W11, W22, 0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        // m1 read of RX returns 0x5A
        tv.push_back(mk(MI,  R1,  0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tv.push_back(mk(MI,  R1,  0, 8'h5A, 2'b10, 1, 1, 2'd1, 8'h00, 0, 0, 8'h00, 8'h5A, 1));
        tv.push_back(mk(MI,  R1,  1, 8'h5A, 2'b10, 1, 1, 2'd1, 8'h00, 0, 1, 8'h00, 8'h5A, 1));
        tv.push_back(mk(MI,  R1,  0, 8'h5A, 2'b10, 1, 1, 2'd1, 8'h00, 0, 0, 8'h00, 8'h5A, 1));
        tv.push_back(mk(MI,  MI,  0, 8'h5A, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(MI,  MI,  0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        // m0 writes 0x41 while m1 is held off
        tv.push_back(mk(W41, MI,  0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tv.push_back(mk(W41, R1,  0, 8'h00, 2'b01, 1, 0, 2'd0, 8'h41, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(W41, R1,  1, 8'h00, 2'b01, 1, 0, 2'd0, 8'h41, 1, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(D41, R1,  0, 8'h00, 2'b01, 0, 0, 2'd0, 8'h41, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(MI,  R1,  1, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tv.push_back(mk(MI,  R1,  0, 8'h00, 2'b00, 0, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tv.push_back(mk(MI,  R1,  0, 8'h00, 2'b10, 1, 1, 2'd1, 8'h00, 0, 0, 8'h00, 8'h00, 1));

        #2;
        chk("reset_grant", grant, 2'b00);
        chk("reset_busy", busy, 0);
        chk("reset_s_stb", {s_stb, s_clk, s_we}, 3'b000);
        chk("reset_acks_errs", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].c0, tv[i].c1, tv[i].ack, tv[i].dout);
            #1;
            chk($sformatf("row%0d grant", i), grant, tv[i].e_grant);
            chk($sformatf("row%0d s_stb", i), s_stb, tv[i].e_stb);
            chk($sformatf("row%0d s_clk", i), s_clk, tv[i].e_stb);
            chk($sformatf("row%0d s_we", i), s_we, tv[i].e_we);
            chk($sformatf("row%0d s_addr", i), s_addr, tv[i].e_addr);
            chk($sformatf("row%0d s_data_in", i), s_data_in, tv[i].e_din);
            chk($sformatf("row%0d m0_ack", i), m0_ack, tv[i].e_a0);
            chk($sformatf("row%0d m1_ack", i), m1_ack, tv[i].e_a1);
            chk($sformatf("row%0d m0_data_out", i), m0_data_out, tv[i].e_d0);
            chk($sformatf("row%0d m1_data_out", i), m1_data_out, tv[i].e_d1);
            chk($sformatf("row%0d busy", i), busy, tv[i].e_busy);
            chk($sformatf("row%0d errs", i), {m0_err, m1_err}, 2'b00);
        end

        // slave never acks m1: grant cycles 2..17
        errs = 0;
        err_at = -1;
        g16 = '0;
        g17 = '0;
        stb17 = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            #1;
            if (m1_err || m0_err) begin
                errs++;
                err_at = k;
            end
            if (k == 16) g16 = grant;
            if (k == 17) begin
                g17 = grant;
                stb17 = s_stb;
            end
        end
`ifdef UART_ARB_TIMEOUT_EN
        chk("timeout_err_count", errs, 1);
        chk("timeout_err_cycle", err_at, 16);
        chk("timeout_grant_c16", g16, 2'b10);
        chk("timeout_release_grant", g17, 2'b00);
        chk("timeout_release_stb", stb17, 0);
`else
        chk("noto_err_count", errs, 0);
        chk("noto_grant_c16", g16, 2'b10);
        chk("noto_grant_held", g17, 2'b10);
        chk("noto_stb_held", stb17, 1);
`endif

        // asynchronous reset in the middle of a granted cycle
        drive(W41, R1, 0, 8'h00);
        for (int i = 0; i < 6 && grant == 2'b00; i++) begin
            @(negedge clk);
            #1;
        end
        chk("pre_reset_granted", grant != 2'b00, 1);
        s_ack = 1'b1;
        #1;
        chk("pre_reset_ack", m0_ack | m1_ack, 1);
        reset = 1'b1;
        #1;
        chk("async_reset_grant", grant, 2'b00);
        chk("async_reset_s_stb", {s_stb, s_clk}, 2'b00);
        chk("async_reset_acks", {m0_ack, m1_ack}, 2'b00);
        chk("async_reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(W11, W22, 0, 8'h00);
        #1;
        chk("post_reset_idle", {grant, busy}, 3'b000);
        @(negedge clk);
        #1;
        chk("post_reset_tie_grant", grant, 2'b01);
        chk("post_reset_s_data_in", s_data_in, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
